dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Shares the single-port synchronous data RAM between the CPU load/store path and one
//   peripheral/DMA requester (e.g. a VGA text buffer or keyboard buffer).
//   - Sits between both requesters and data_memory.
//   - Translates MARS addresses (base 0x10000000) to RAM addresses and range-checks them.
//   - Returns read data with an ack pulse; drives a CPU stall while a CPU access is pending.
// PARAMETERS
//   DATA_WIDTH  32            data bus width
//   ADDR_BASE   32'h10000000  address subtracted from requester address to form RAM offset
//   RAM_AW      12            RAM address width; valid offset range 0 .. 2**RAM_AW-1
// PORTS
//   clk         in   1           system clock; the RAM is clocked by the same clk
//   rst         in   1           asynchronous, active-low reset
//   cpu_req     in   1           CPU access request; held until cpu_ack
//   cpu_we      in   1           1 = write, 0 = read
//   cpu_addr    in   32          MARS byte address (rs + offset)
//   cpu_wdata   in   DATA_WIDTH  store data (rt)
//   cpu_rdata   out  DATA_WIDTH  load data, valid when cpu_ack=1
//   cpu_ack     out  1           one-cycle completion pulse
//   cpu_err     out  1           pulses with cpu_ack when the address was out of range
//   cpu_stall   out  1           cpu_req & ~cpu_ack (combinational)
//   dev_req/dev_we/dev_addr/dev_wdata/dev_rdata/dev_ack/dev_err
//               same directions, widths and meanings as the cpu_* set, for the peripheral
//   ram_address out  RAM_AW      registered RAM address
//   ram_data    out  DATA_WIDTH  registered RAM write data
//   ram_wren    out  1           registered RAM write enable
//   ram_q       in   DATA_WIDTH  RAM read data; valid the cycle after the address edge
// BEHAVIOUR
//   FSM states IDLE, ISSUE, RESP. The FSM and all ram_* outputs are registered.
//   - IDLE: when any req=1, arbitrate, latch the winner's we/addr/wdata and drive ram_*,
//     then go to ISSUE.
//   - ISSUE: RAM samples ram_* on the closing edge; ram_wren returns to 0 after this
//     cycle. Go to RESP.
//   - RESP: ram_q is valid. Pulse the winner's ack for 1 cycle; winner rdata = ram_q
//     for a read, 0 for a write.
//     - If any req=1 in RESP, arbitrate and latch exactly as in IDLE, then go to ISSUE.
//     - Otherwise go to IDLE.
//   Latency: req first seen high at edge E; ack is high in the cycle after E+1 (2 cycles).
//   Throughput: one access per 2 cycles.
//   Handshake:
//   - A requester holds req and its operands stable until ack.
//   - req still high in the ack cycle is a NEW request.
//   - Operand changes before ack are ignored; operands are latched at grant.
//   - ack and err are never high for the non-granted requester.
//   - rdata of the non-acked requester holds its last value.
//   Arbitration is round-robin on a last-grant pointer:
//   - Simultaneous requests: the requester not granted last wins.
//   - After reset the pointer favours the CPU, so the CPU wins the first tie.
//   - A single requester is granted every 2 cycles.
//   Address: off = addr - ADDR_BASE (32-bit wrap); ram_address = off[RAM_AW-1:0].
//   - off >= 2**RAM_AW (this includes addr < ADDR_BASE through the wrap) is out of range:
//     - ram_wren stays 0;
//     - the access still takes 2 cycles;
//     - ack returns rdata = 0 and err = 1.
//   Reset (rst=0, asynchronous, at any time, including mid-access):
//   - state=IDLE, pointer=CPU;
//   - ram_wren=0, ram_address=0, ram_data=0;
//   - all ack=0, err=0, rdata=0;
//   - an access in ISSUE is dropped; no ack is ever produced for it.
// CONFIGURATION
//   DMEM_ARB_CPU_PRIO_EN defined: fixed priority, CPU always wins simultaneous requests;
//     the device is served only when cpu_req=0 at an arbitration point.
//   DMEM_ARB_CPU_PRIO_EN undefined (default): round-robin as described above.
// TESTING
//   1. Reset, then CPU write 0xDEADBEEF @0x10000004:
//      ram_wren=1 with ram_address=4 one cycle; cpu_ack 2 cycles after req; cpu_stall high
//      only in the wait cycle.
//   2. CPU read @0x10000004 with RAM model returning 0xDEADBEEF:
//      cpu_rdata=0xDEADBEEF with cpu_ack; dev_ack stays 0.
//   3. cpu_req and dev_req held high together for 8 cycles:
//      acks alternate CPU, DEV, CPU, DEV; with DMEM_ARB_CPU_PRIO_EN, 4 cpu_acks and 0 dev_acks.
//   4. dev read @0x0FFFFFFC and CPU write @0x10000000 + 2**RAM_AW:
//      both give ack+err, rdata=0, and ram_wren never rises.
//   5. Assert rst in the ISSUE cycle of a CPU write:
//      ram_wren drops immediately, no cpu_ack; after release a new CPU read completes
//      in 2 cycles.
//   6. cpu_req held high across its ack with the device idle:
//      a second access starts and acks 2 cycles later, at a different address.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Purpose : shares one single-port synchronous data RAM between the CPU load/store path and one device requester.
// Latency : request seen at edge E is acked in the cycle after E+1, and one access completes every 2 cycles.
// Backpres: a requester holds req and its operands until ack; cpu_stall = cpu_req & ~cpu_ack.
//
// Ports:
//   clk, rst                      clock; asynchronous active-low reset
//   cpu_req/we/addr/wdata         CPU request. The address is a MARS byte address.
//   cpu_rdata/ack/err/stall       CPU response. ack and err are one-cycle pulses. rdata holds between acks.
//   dev_req/we/addr/wdata         device request, with the same meanings as the CPU set
//   dev_rdata/ack/err             device response
//   ram_address/data/wren         registered RAM command
//   ram_q                         RAM read data, valid the cycle after the address edge
//
// Build option: define DMEM_ARB_CPU_PRIO_EN to give the CPU fixed priority.
// Without it, arbitration is round-robin on the last grant.
module dmem_arbiter #(
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] ADDR_BASE  = 32'h1000_0000,
  parameter int          RAM_AW     = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [31:0]           cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ack,
  output logic                  cpu_err,
  output logic                  cpu_stall,
  input  logic                  dev_req,
  input  logic                  dev_we,
  input  logic [31:0]           dev_addr,
  input  logic [DATA_WIDTH-1:0] dev_wdata,
  output logic [DATA_WIDTH-1:0] dev_rdata,
  output logic                  dev_ack,
  output logic                  dev_err,
  output logic [RAM_AW-1:0]     ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t                state, state_nxt;
  logic                  last_dev;     // 1 = device was granted last (reset value lets the CPU win the first tie)
  logic                  gnt_dev_q;    // owner of the access in flight
  logic                  we_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] cpu_rdata_q;
  logic [DATA_WIDTH-1:0] dev_rdata_q;

  logic                  any_req;
  logic                  pick_dev;
  logic                  grant;
  logic                  resp;
  logic                  sel_we;
  logic [31:0]           sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [31:0]           sel_off;
  logic                  sel_oor;
  logic [DATA_WIDTH-1:0] resp_dat;

  assign any_req = cpu_req | dev_req;

`ifdef DMEM_ARB_CPU_PRIO_EN
  assign pick_dev = ~cpu_req;
`else
  // The device wins only if it is alone, or if both request and the CPU had the last grant.
  assign pick_dev = dev_req & (~cpu_req | ~last_dev);
`endif

  assign sel_we    = pick_dev ? dev_we    : cpu_we;
  assign sel_addr  = pick_dev ? dev_addr  : cpu_addr;
  assign sel_wdata = pick_dev ? dev_wdata : cpu_wdata;
  // A wrapping subtract makes addresses below the base land far out of range.
  assign sel_off   = sel_addr - ADDR_BASE;
  assign sel_oor   = |sel_off[31:RAM_AW];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    resp      = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_req) begin
          grant     = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: state_nxt = S_RESP;
      S_RESP: begin
        resp = 1'b1;
        // A req still high in the ack cycle is a fresh request, so re-arbitrate right away.
        if (any_req) begin
          grant     = 1'b1;
          state_nxt = S_ISSUE;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Writes and out-of-range accesses return zero data.
  assign resp_dat  = (we_q | err_q) ? '0 : ram_q;

  assign cpu_ack   = resp & ~gnt_dev_q;
  assign dev_ack   = resp &  gnt_dev_q;
  assign cpu_err   = cpu_ack & err_q;
  assign dev_err   = dev_ack & err_q;
  assign cpu_rdata = cpu_ack ? resp_dat : cpu_rdata_q;
  assign dev_rdata = dev_ack ? resp_dat : dev_rdata_q;
  assign cpu_stall = cpu_req & ~cpu_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_dev    <= 1'b1;
      gnt_dev_q   <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
      cpu_rdata_q <= '0;
      dev_rdata_q <= '0;
    end else begin
      if (grant) begin
        gnt_dev_q   <= pick_dev;
        last_dev    <= pick_dev;
        we_q        <= sel_we;
        err_q       <= sel_oor;
        ram_address <= sel_off[RAM_AW-1:0];
        ram_data    <= sel_wdata;
        ram_wren    <= sel_we & ~sel_oor;
      end else begin
        // The RAM has taken the command at the end of ISSUE, so the write enable must not linger.
        ram_wren <= 1'b0;
      end
      if (cpu_ack) cpu_rdata_q <= resp_dat;
      if (dev_ack) dev_rdata_q <= resp_dat;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose : randomized and directed bench for dmem_arbiter, using a scoreboard and a behavioural RAM model.
// Latency : expects each ack in the cycle after the grant edge + 1.
// Backpres: drivers hold req until ack, and drop or renew it in the ack cycle.
module tb_dmem_arbiter;
  localparam int          DW   = 32;
  localparam int          AW   = 12;
  localparam logic [31:0] BASE = 32'h1000_0000;

  typedef struct packed {
    logic [31:0] dat;
    logic        err;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          cpu_req, cpu_we, cpu_ack, cpu_err, cpu_stall;
  logic [31:0]   cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dev_req, dev_we, dev_ack, dev_err;
  logic [31:0]   dev_addr;
  logic [DW-1:0] dev_wdata, dev_rdata;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data, ram_q;
  logic          ram_wren;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   wren_cnt = 0;
  exp_t cpu_exp[$];
  exp_t dev_exp[$];
  logic [31:0] ref_mem [0:(1<<AW)-1];  // the bench's view of memory contents
  logic [31:0] ram_mem [0:(1<<AW)-1];  // the RAM attached to the DUT
  logic [31:0] last_cpu, last_dev;

  dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_BASE(BASE), .RAM_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_stall(cpu_stall),
    .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .dev_rdata(dev_rdata), .dev_ack(dev_ack), .dev_err(dev_err),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM with read-before-write behaviour.
  always @(posedge clk) begin
    if (ram_wren) ram_mem[ram_address] <= ram_data;
    ram_q <= ram_mem[ram_address];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected response from address arithmetic alone. Writes update the reference memory at issue time.
  function automatic exp_t model(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] off;
    exp_t e;
    off   = addr - BASE;
    e.dat = '0;
    e.err = 1'b0;
    if (off >= 32'(1 << AW))  e.err = 1'b1;
    else if (we)              ref_mem[off[AW-1:0]] = wd;
    else                      e.dat = ref_mem[off[AW-1:0]];
    return e;
  endfunction

  // Monitor: pops the scoreboard on every ack and checks the hold and exclusivity rules every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      last_cpu = '0;
      last_dev = '0;
      chk("ack_in_reset", 32'({cpu_ack, dev_ack, cpu_err, dev_err}), 32'd0);
    end else begin
      chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req & ~cpu_ack));
      if (cpu_ack && dev_ack) chk("both_acks", 32'd1, 32'd0);
      if (ram_wren) wren_cnt++;
      if (cpu_ack) begin
        if (cpu_exp.size() == 0) chk("cpu_unexpected_ack", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = cpu_exp.pop_front();
          chk("cpu_rdata", cpu_rdata, e.dat);
          chk("cpu_err", 32'(cpu_err), 32'(e.err));
        end
        last_cpu = cpu_rdata;
      end else begin
        chk("cpu_rdata_hold", cpu_rdata, last_cpu);
      end
      if (dev_ack) begin
        if (dev_exp.size() == 0) chk("dev_unexpected_ack", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = dev_exp.pop_front();
          chk("dev_rdata", dev_rdata, e.dat);
          chk("dev_err", 32'(dev_err), 32'(e.err));
        end
        last_dev = dev_rdata;
      end else begin
        chk("dev_rdata_hold", dev_rdata, last_dev);
      end
    end
  end

  // Called just after an edge. lat counts negedges up to and including the ack cycle.
  task automatic cpu_op(input logic we, input logic [31:0] addr, input logic [31:0] wd, output int lat);
    cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
    cpu_exp.push_back(model(we, addr, wd));
    lat = 0;
    do begin @(negedge clk); lat++; end while (!cpu_ack && lat < 200);
    if (!cpu_ack) chk("cpu_ack_timeout", 32'd0, 32'd1);
    #1 cpu_req = 1'b0;
  endtask

  task automatic dev_op(input logic we, input logic [31:0] addr, input logic [31:0] wd, output int lat);
    dev_we = we; dev_addr = addr; dev_wdata = wd; dev_req = 1'b1;
    dev_exp.push_back(model(we, addr, wd));
    lat = 0;
    do begin @(negedge clk); lat++; end while (!dev_ack && lat < 200);
    if (!dev_ack) chk("dev_ack_timeout", 32'd0, 32'd1);
    #1 dev_req = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b0; cpu_req = 1'b0; dev_req = 1'b0;
    cpu_exp.delete(); dev_exp.delete();
    @(negedge clk);
    chk("rst_ram_wren", 32'(ram_wren), 32'd0);
    chk("rst_ram_address", 32'(ram_address), 32'd0);
    chk("rst_ram_data", ram_data, 32'd0);
    chk("rst_rdata", cpu_rdata | dev_rdata, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
  endtask

  function automatic logic [31:0] rnd_addr(input logic [31:0] region);
    logic [31:0] a;
    if ($urandom_range(0, 7) == 0)
      a = ($urandom_range(0, 1) == 1) ? BASE + 32'h1000 + 32'(4 * $urandom_range(0, 255))
                                      : BASE - 32'(4 * (1 + $urandom_range(0, 255)));
    else
      a = BASE + region + 32'(4 * $urandom_range(0, 63));
    return a;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1);
  end

  initial begin
    int lat, lat2, n, nack, wren0;
    int seq [4];
    for (int i = 0; i < (1 << AW); i++) begin ref_mem[i] = '0; ram_mem[i] = '0; end
    cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; dev_we = 0; dev_addr = 0; dev_wdata = 0;
    apply_reset();

    // 1: CPU write. One write strobe at offset 4 in the ISSUE cycle, then an ack.
    @(posedge clk); #1;
    fork
      cpu_op(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, lat);
      begin
        @(negedge clk); chk("t1_wren_idle", 32'(ram_wren), 32'd0);
        @(negedge clk); chk("t1_wren_issue", 32'(ram_wren), 32'd1);
        chk("t1_addr", 32'(ram_address), 32'd4);
        chk("t1_data", ram_data, 32'hDEAD_BEEF);
        @(negedge clk); chk("t1_wren_resp", 32'(ram_wren), 32'd0);
      end
    join
    chk("t1_latency", 32'(lat), 32'd3);

    // 2: CPU read back. Any dev ack here would pop an empty queue.
    @(posedge clk); #1;
    cpu_op(1'b0, 32'h1000_0004, 32'h0, lat);
    chk("t2_latency", 32'(lat), 32'd3);

    // 3: both requesters held together from reset.
    apply_reset();
    @(posedge clk); #1;
    cpu_we = 0; cpu_addr = 32'h1000_0004; dev_we = 0; dev_addr = 32'h1000_0008;
`ifdef DMEM_ARB_CPU_PRIO_EN
    repeat (4) cpu_exp.push_back(model(1'b0, cpu_addr, 32'h0));
`else
    repeat (2) begin
      cpu_exp.push_back(model(1'b0, cpu_addr, 32'h0));
      dev_exp.push_back(model(1'b0, dev_addr, 32'h0));
    end
`endif
    cpu_req = 1'b1; dev_req = 1'b1;
    n = 0; nack = 0;
    while (nack < 4 && n < 20) begin
      @(negedge clk); n++;
      if (cpu_ack) begin seq[nack] = 0; nack++; end
      else if (dev_ack) begin seq[nack] = 1; nack++; end
    end
    #1 cpu_req = 1'b0; dev_req = 1'b0;
    chk("t3_ack_count", 32'(nack), 32'd4);
    chk("t3_cycles", 32'(n), 32'd9);
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_CPU_PRIO_EN
      chk($sformatf("t3_order%0d", i), 32'(seq[i]), 32'd0);
`else
      chk($sformatf("t3_order%0d", i), 32'(seq[i]), 32'(i % 2));
`endif
    end

    // 4: out-of-range on both sides. Both must ack with err, and no write strobe may appear.
    @(posedge clk); #1;
    wren0 = wren_cnt;
    fork
      dev_op(1'b0, 32'h0FFF_FFFC, 32'h0, lat);
      cpu_op(1'b1, BASE + 32'h1000, 32'hFFFF_FFFF, lat2);
    join
    @(negedge clk);
    chk("t4_no_wren", 32'(wren_cnt), 32'(wren0));

    // 5: reset asserted during the ISSUE cycle of a CPU write.
    apply_reset();
    @(posedge clk); #1;
    cpu_we = 1; cpu_addr = 32'h1000_0010; cpu_wdata = 32'h1234_5678; cpu_req = 1'b1;
    @(posedge clk); #1;
    chk("t5_wren_issue", 32'(ram_wren), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("t5_wren_dropped", 32'(ram_wren), 32'd0);
    chk("t5_addr_cleared", 32'(ram_address), 32'd0);
    cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    cpu_op(1'b0, 32'h1000_0010, 32'h0, lat);  // the dropped write must not have landed
    chk("t5_latency", 32'(lat), 32'd3);

    // 6: req held across the ack with new operands starts a second access.
    @(posedge clk); #1;
    cpu_op(1'b1, 32'h1000_0020, 32'hA5A5_0001, lat);
    cpu_we = 1; cpu_addr = 32'h1000_0024; cpu_wdata = 32'h5A5A_0002; cpu_req = 1'b1;
    cpu_exp.push_back(model(1'b1, cpu_addr, cpu_wdata));
    n = 0;
    do begin
      @(negedge clk); n++;
      if (n == 1) begin
        chk("t6_addr", 32'(ram_address), 32'h24);
        chk("t6_wren", 32'(ram_wren), 32'd1);
      end
    end while (!cpu_ack && n < 20);
    #1 cpu_req = 1'b0;
    chk("t6_latency", 32'(n), 32'd2);
    @(posedge clk); #1;
    cpu_op(1'b0, 32'h1000_0024, 32'h0, lat);
    cpu_op(1'b0, 32'h1000_0020, 32'h0, lat);

    // Random traffic. Each requester works in its own address window.
    @(posedge clk); #1;
    fork
      repeat (60) begin
        int k, l;
        cpu_op(1'(($urandom_range(0, 1))), rnd_addr(32'h100), $urandom, l);
        k = $urandom_range(0, 2);
        if (k > 0) begin repeat (k) @(posedge clk); #1; end
      end
      repeat (60) begin
        int k, l;
        dev_op(1'(($urandom_range(0, 1))), rnd_addr(32'h200), $urandom, l);
        k = $urandom_range(0, 2);
        if (k > 0) begin repeat (k) @(posedge clk); #1; end
      end
    join

    repeat (4) @(posedge clk);
    chk("cpu_queue_empty", 32'(cpu_exp.size()), 32'd0);
    chk("dev_queue_empty", 32'(dev_exp.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
